machine_csr_irq: RTL and testbench

//  RV32 machine-mode CSR file plus interrupt arbiter for the pCPU core.

---
 rtl/machine_csr_irq_pkg.sv | 41 ++++
 rtl/machine_csr_irq_arbiter.sv | 24 ++
 rtl/machine_csr_irq.sv | 231 +++++++++++++++++++++++
 tb/tb_machine_csr_irq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_csr_irq_pkg.sv
// Shared definitions for the machine-mode CSR file and interrupt arbiter:
// CSR addresses, interrupt cause codes, mtvec modes and reset values.
package machine_csr_irq_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MCNTINH  = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTR   = 12'hB02;
  localparam logic [11:0] CSR_MINSTRH  = 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTR    = 12'hC02;
  localparam logic [11:0] CSR_INSTRH   = 12'hC82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [4:0] IRQ_MSI   = 5'd3;
  localparam logic [4:0] IRQ_MTI   = 5'd7;
  localparam logic [4:0] IRQ_PLAT0 = 5'd16;

  localparam logic [1:0] MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MODE_VECTORED = 2'd1;

  localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
  localparam logic [31:0] MISA_VAL    = 32'h4000_0100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACKD
  } irq_st_e;

endpackage

// File: rtl/machine_csr_irq_arbiter.sv
// Fixed-priority interrupt encoder: highest platform line first,
// then software, then timer.
module machine_csr_irq_arbiter #(
  parameter int NEXT = 4
) (
  input  logic [31:0] pend,
  output logic        valid,
  output logic [4:0]  cause
);
  import machine_csr_irq_pkg::*;

  // pend is already masked by mie, so any set bit is a real source
  assign valid = |pend;

  always_comb begin
    cause = '0;
    if (pend[IRQ_MTI]) cause = IRQ_MTI;
    if (pend[IRQ_MSI]) cause = IRQ_MSI;
    for (int i = 0; i < NEXT; i++) begin
      if (pend[16+i]) cause = IRQ_PLAT0 + 5'(i);
    end
  end

endmodule

// File: rtl/machine_csr_irq.sv
// RV32 machine-mode CSR file with counters and a held
// interrupt request towards the execute stage.
module machine_csr_irq #(
  parameter int          NEXT        = 4,
  parameter logic [31:0] HARTID      = 32'h0,
  parameter bit          VECTORED_EN = 1'b1,
  parameter bit          CNT_EN      = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_addr,
  input  logic [31:0]     csr_wdata,
  input  logic            csr_we,
  output logic [31:0]     csr_rdata,
  output logic            csr_illegal,
  input  logic [NEXT-1:0] irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  input  logic            exc_enter,
  input  logic [3:0]      exc_cause,
  input  logic [31:0]     exc_pc,
  input  logic [31:0]     exc_tval,
  input  logic            mret,
  input  logic            instret,
  output logic            int_req,
  output logic [4:0]      int_cause,
  input  logic            int_ack,
  output logic [31:0]     trap_pc,
  output logic [31:0]     mepc_out
);
  import machine_csr_irq_pkg::*;

  localparam logic [31:0] MIE_MASK =
    32'h88 | (((32'h1 << NEXT) - 32'h1) << 16);

  logic        st_mie, st_mpie, sw_msip;
  logic        ih_cy, ih_ir;
  logic [31:0] mie_r, mtvec_r, mscratch;
  logic [31:0] mepc, mcause, mtval;
  logic [63:0] mcycle, minstret;
  logic [31:0] mip_v, pend;
  logic        unk, ro, wr_ok;
  logic        arb_valid, irq_ok;
  logic [4:0]  arb_cause, cause_q;
  logic [31:0] base;
  irq_st_e     state_q, state_d;

  always_comb begin
    mip_v = '0;
    mip_v[16 +: NEXT] = irq_ext;
    mip_v[7] = irq_timer;
    mip_v[3] = irq_soft | sw_msip;
  end

  assign pend = mip_v & mie_r;

  machine_csr_irq_arbiter #(.NEXT(NEXT)) u_arb (
    .pend  (pend),
    .valid (arb_valid),
    .cause (arb_cause)
  );

  assign irq_ok = st_mie & arb_valid;

  always_comb begin
    csr_rdata = '0;
    unk = 1'b0;
    ro  = 1'b0;
    unique case (csr_addr)
      CSR_MSTATUS:
        csr_rdata = MSTATUS_RST
          | {24'b0, st_mpie, 3'b0, st_mie, 3'b0};
      CSR_MISA: begin
        csr_rdata = MISA_VAL;
        ro = 1'b1;
      end
      CSR_MIE:      csr_rdata = mie_r;
      CSR_MTVEC:    csr_rdata = mtvec_r;
      CSR_MCNTINH:  csr_rdata = {29'b0, ih_ir, 1'b0, ih_cy};
      CSR_MSCRATCH: csr_rdata = mscratch;
      CSR_MEPC:     csr_rdata = mepc;
      CSR_MCAUSE:   csr_rdata = mcause;
      CSR_MTVAL:    csr_rdata = mtval;
      CSR_MIP:      csr_rdata = mip_v;
      CSR_MCYCLE:   csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:  csr_rdata = mcycle[63:32];
      CSR_MINSTR:   csr_rdata = minstret[31:0];
      CSR_MINSTRH:  csr_rdata = minstret[63:32];
      CSR_CYCLE: begin
        csr_rdata = mcycle[31:0];
        ro = 1'b1;
      end
      CSR_CYCLEH: begin
        csr_rdata = mcycle[63:32];
        ro = 1'b1;
      end
      CSR_INSTR: begin
        csr_rdata = minstret[31:0];
        ro = 1'b1;
      end
      CSR_INSTRH: begin
        csr_rdata = minstret[63:32];
        ro = 1'b1;
      end
      CSR_MHARTID: begin
        csr_rdata = HARTID;
        ro = 1'b1;
      end
      default: unk = 1'b1;
    endcase
  end

  assign csr_illegal = unk | (csr_we & ro);
  assign wr_ok = csr_we & ~csr_illegal;

  // csr_we outranks every trap event, even when the write is illegal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      sw_msip  <= 1'b0;
      ih_cy    <= 1'b0;
      ih_ir    <= 1'b0;
      mie_r    <= '0;
      mtvec_r  <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (csr_we) begin
      if (wr_ok) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            st_mie  <= csr_wdata[3];
            st_mpie <= csr_wdata[7];
          end
          CSR_MIE: mie_r <= csr_wdata & MIE_MASK;
          CSR_MTVEC:
            mtvec_r <= {csr_wdata[31:2],
              (csr_wdata[1:0] == MODE_VECTORED && VECTORED_EN)
                ? MODE_VECTORED : MODE_DIRECT};
          CSR_MCNTINH: begin
            ih_cy <= csr_wdata[0];
            ih_ir <= csr_wdata[2];
          end
          CSR_MSCRATCH: mscratch <= csr_wdata;
          CSR_MEPC:     mepc <= csr_wdata & ~32'h3;
          CSR_MCAUSE:   mcause <= csr_wdata;
          CSR_MTVAL:    mtval <= csr_wdata;
          CSR_MIP:      sw_msip <= csr_wdata[3];
          default: ;
        endcase
      end
    end else if (exc_enter) begin
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
      mepc    <= exc_pc & ~32'h3;
      mcause  <= {28'b0, exc_cause};
      mtval   <= exc_tval;
    end else if (int_ack) begin
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
      mepc    <= exc_pc & ~32'h3;
      mcause  <= {1'b1, 26'b0, cause_q};
      mtval   <= '0;
    end else if (mret) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else if (CNT_EN) begin
      if (wr_ok && csr_addr == CSR_MCYCLE)
        mcycle[31:0] <= csr_wdata;
      else if (wr_ok && csr_addr == CSR_MCYCLEH)
        mcycle[63:32] <= csr_wdata;
      else if (!ih_cy)
        mcycle <= mcycle + 64'd1;
      if (wr_ok && csr_addr == CSR_MINSTR)
        minstret[31:0] <= csr_wdata;
      else if (wr_ok && csr_addr == CSR_MINSTRH)
        minstret[63:32] <= csr_wdata;
      else if (!ih_ir && instret)
        minstret <= minstret + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_REQ) cause_q <= arb_cause;
    end
  end

  // ACKD spends one cycle so a still-high level cannot re-request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (irq_ok) state_d = ST_REQ;
      ST_REQ: begin
        if (int_ack)      state_d = ST_ACKD;
        else if (!irq_ok) state_d = ST_IDLE;
      end
      ST_ACKD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    int_req   = (state_q == ST_REQ);
    int_cause = cause_q;
  end

  assign base = {mtvec_r[31:2], 2'b00};

  always_comb begin
    trap_pc = base;
    if (int_req && mtvec_r[1:0] == MODE_VECTORED)
      trap_pc = base + {25'b0, cause_q, 2'b00};
  end

  assign mepc_out = mepc;

endmodule

// File: tb/tb_machine_csr_irq.sv
// Directed bench for machine_csr_irq: CSR access, interrupt
// request flow, trap entry/exit and 64-bit counters.
module tb_machine_csr_irq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [3:0]  irq_ext;
  logic        irq_timer, irq_soft;
  logic        exc_enter;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        mret, instret;
  logic        int_req;
  logic [4:0]  int_cause;
  logic        int_ack;
  logic [31:0] trap_pc, mepc_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  machine_csr_irq #(
    .NEXT(4), .HARTID(32'h5),
    .VECTORED_EN(1'b1), .CNT_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_we(csr_we), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal),
    .irq_ext(irq_ext), .irq_timer(irq_timer),
    .irq_soft(irq_soft),
    .exc_enter(exc_enter), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret(mret), .instret(instret),
    .int_req(int_req), .int_cause(int_cause),
    .int_ack(int_ack), .trap_pc(trap_pc),
    .mepc_out(mepc_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_we    = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic chkrd(input string tag, input logic [11:0] a,
                       input logic [31:0] exp);
    csr_we   = 1'b0;
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    csr_addr = '0; csr_wdata = '0; csr_we = 1'b0;
    irq_ext = '0; irq_timer = 1'b0; irq_soft = 1'b0;
    exc_enter = 1'b0; exc_cause = '0;
    exc_pc = '0; exc_tval = '0;
    mret = 1'b0; instret = 1'b0; int_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, int_req}, 32'h0);
    chk("rst_cause", {27'b0, int_cause}, 32'h0);
    chk("rst_mepc", mepc_out, 32'h0);
    rst_n = 1'b1;
    tick();

    chkrd("mstatus_rst", 12'h300, 32'h0000_1800);
    chkrd("misa", 12'h301, 32'h4000_0100);
    chkrd("mhartid", 12'hF14, 32'h5);
    chkrd("mie_rst", 12'h304, 32'h0);
    csr_addr = 12'h7C0;
    #1;
    chk("bad_ill", {31'b0, csr_illegal}, 32'h1);
    chk("bad_rdata", csr_rdata, 32'h0);
    tick();

    csr_addr = 12'h301; csr_wdata = 32'h0; csr_we = 1'b1;
    #1;
    chk("ro_ill", {31'b0, csr_illegal}, 32'h1);
    tick();
    csr_we = 1'b0;
    chkrd("misa_keep", 12'h301, 32'h4000_0100);
    csr_addr = 12'h340; csr_wdata = 32'hA5A5_A5A5; csr_we = 1'b1;
    #1;
    chk("rw_legal", {31'b0, csr_illegal}, 32'h0);
    tick();
    csr_we = 1'b0;
    chkrd("mscratch", 12'h340, 32'hA5A5_A5A5);
    wr(12'h305, 32'h8000_0002);
    chkrd("mtvec_m2", 12'h305, 32'h8000_0000);

    // vectored platform interrupt, then a higher line joins
    wr(12'h305, 32'h8000_0001);
    chkrd("mtvec_m1", 12'h305, 32'h8000_0001);
    wr(12'h304, 32'hFFFF_FFFF);
    chkrd("mie_mask", 12'h304, 32'h000F_0088);
    wr(12'h304, 32'h0004_0000);
    irq_ext = 4'b0100;
    wr(12'h300, 32'h8);
    n = 0;
    while (!int_req && n < 3) begin
      tick();
      n++;
    end
    chk("req_ext", {31'b0, int_req}, 32'h1);
    chk("cause_18", {27'b0, int_cause}, 32'd18);
    chk("tpc_18", trap_pc, 32'h8000_0048);
    chkrd("mip_ext", 12'h344, 32'h0004_0000);
    irq_ext = 4'b1100;
    wr(12'h304, 32'h000C_0000);
    tick();
    chk("req_keep", {31'b0, int_req}, 32'h1);
    chk("cause_19", {27'b0, int_cause}, 32'd19);
    chk("tpc_19", trap_pc, 32'h8000_004C);
    wr(12'h343, 32'h55);
    exc_pc = 32'h2002; int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("ack_drop", {31'b0, int_req}, 32'h0);
    chk("ack_mepc", mepc_out, 32'h2000);
    chkrd("ack_mcause", 12'h342, 32'h8000_0013);
    chkrd("ack_mstat", 12'h300, 32'h0000_1880);
    chkrd("ack_mtval", 12'h343, 32'h0);
    irq_ext = 4'b0000;
    tick();
    chk("ackd_idle", {31'b0, int_req}, 32'h0);

    // timer request withdrawn by clearing MIE
    wr(12'h304, 32'h80);
    irq_timer = 1'b1;
    wr(12'h300, 32'h8);
    tick();
    chk("req_mti", {31'b0, int_req}, 32'h1);
    chk("cause_mti", {27'b0, int_cause}, 32'd7);
    chk("tpc_mti", trap_pc, 32'h8000_001C);
    wr(12'h300, 32'h0);
    tick();
    chk("withdraw", {31'b0, int_req}, 32'h0);
    chkrd("wd_mcause", 12'h342, 32'h8000_0013);
    irq_timer = 1'b0;

    // exception entry and mret
    wr(12'h305, 32'h8000_0003);
    chkrd("mtvec_m3", 12'h305, 32'h8000_0000);
    chk("tpc_base", trap_pc, 32'h8000_0000);
    wr(12'h300, 32'h8);
    exc_enter = 1'b1; exc_cause = 4'd2;
    exc_pc = 32'h100; exc_tval = 32'hDEAD;
    tick();
    exc_enter = 1'b0;
    chk("exc_mepc", mepc_out, 32'h100);
    chkrd("exc_mcause", 12'h342, 32'h2);
    chkrd("exc_mtval", 12'h343, 32'hDEAD);
    chkrd("exc_mstat", 12'h300, 32'h0000_1880);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chkrd("mret_mstat", 12'h300, 32'h0000_1888);

    // csr write beats a simultaneous exception
    csr_addr = 12'h341; csr_wdata = 32'h1234_5677;
    csr_we = 1'b1; exc_enter = 1'b1;
    exc_cause = 4'd5; exc_pc = 32'h400;
    tick();
    csr_we = 1'b0; exc_enter = 1'b0;
    chk("wr_mepc", mepc_out, 32'h1234_5674);
    chkrd("wr_mstat", 12'h300, 32'h0000_1888);
    chkrd("wr_mcause", 12'h342, 32'h2);

    // 64-bit cycle counter wrap and inhibit
    chkrd("instr_0", 12'hB02, 32'h0);
    wr(12'hB00, 32'hFFFF_FFFE);
    wr(12'hB80, 32'hFFFF_FFFF);
    chkrd("cyc_lo_w", 12'hB00, 32'hFFFF_FFFE);
    chkrd("cyc_hi_w", 12'hB80, 32'hFFFF_FFFF);
    tick();
    chkrd("cyc_lo_1", 12'hB00, 32'hFFFF_FFFF);
    chkrd("cyc_hi_1", 12'hC80, 32'hFFFF_FFFF);
    tick();
    chkrd("cyc_wrap_lo", 12'hB00, 32'h0);
    chkrd("cyc_wrap_hi", 12'hB80, 32'h0);
    wr(12'h320, 32'h1);
    tick();
    tick();
    chkrd("cyc_frozen", 12'hC00, 32'h1);
    chkrd("inhibit", 12'h320, 32'h1);

    instret = 1'b1;
    tick(); tick(); tick();
    instret = 1'b0;
    tick();
    instret = 1'b1;
    tick();
    instret = 1'b0;
    chkrd("instr_4", 12'hB02, 32'h4);
    chkrd("instr_sh", 12'hC02, 32'h4);
    wr(12'h320, 32'h5);
    instret = 1'b1;
    tick(); tick();
    instret = 1'b0;
    chkrd("instr_inh", 12'hB02, 32'h4);
    chkrd("instr_hi", 12'hB82, 32'h0);
    csr_addr = 12'hC00; csr_wdata = 32'h77; csr_we = 1'b1;
    #1;
    chk("shadow_ill", {31'b0, csr_illegal}, 32'h1);
    tick();
    csr_we = 1'b0;
    chkrd("shadow_keep", 12'hC00, 32'h1);

    // software interrupt, then async reset mid-request
    wr(12'h304, 32'h8);
    wr(12'h344, 32'h8);
    tick();
    chk("req_msi", {31'b0, int_req}, 32'h1);
    chk("cause_msi", {27'b0, int_cause}, 32'd3);
    chkrd("mip_msi", 12'h344, 32'h8);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, int_req}, 32'h0);
    chk("arst_cause", {27'b0, int_cause}, 32'h0);
    chk("arst_mepc", mepc_out, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
